trig_histogrammer: RTL and testbench

- Upstream feeder of the serial command processor's histogram (cmd 10) and delay (cmd 11) readouts.
- Synchronises 8 trigger lines into the board clock domain and counts rising edges per channel into 32-bit saturating counters.
- Measures the ch0-to-ch1 edge delay in clock cycles.
- Clears its counters on a rising edge of the processor's `resethist` request.

---
 rtl/trig_histogrammer_if.sv | 15 +
 rtl/trig_histogrammer.sv | 73 +++++++
 tb/tb_trig_histogrammer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/trig_histogrammer_if.sv
// trig_histogrammer_if: trigger inputs, control levels and histogram/delay readout bundle
interface trig_histogrammer_if #(
  parameter int NCHAN = 8,
  parameter int CNTW  = 32,
  parameter int DLYW  = 8
);
  logic [NCHAN-1:0]           trig_in;
  logic                       count_enable;
  logic                       resethist;
  logic [NCHAN-1:0][CNTW-1:0] histos;
  logic [DLYW-1:0]            delaycounter;
  logic [NCHAN-1:0]           overflow;
  modport master (output trig_in, count_enable, resethist, input histos, delaycounter, overflow);
  modport slave  (input trig_in, count_enable, resethist, output histos, delaycounter, overflow);
endinterface

// File: rtl/trig_histogrammer.sv
// trig_histogrammer: synchronised per-channel rising-edge counters and ch0->ch1 delay timer
module trig_histogrammer #(
  parameter int NCHAN       = 8,
  parameter int CNTW        = 32,
  parameter int DLYW        = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                reset_n,
  trig_histogrammer_if.slave bus
);
  typedef enum logic {IDLE, ARMED} st_t;
  st_t                               st_q, st_d;
  logic [SYNC_STAGES-1:0][NCHAN-1:0] sync_q;
  logic [NCHAN-1:0]                  prev_q, edg, ovf_q, ovf_d;
  logic [NCHAN-1:0][CNTW-1:0]        cnt_q, cnt_d;
  logic [DLYW-1:0]                   dly_q, dly_d, tmr_q, tmr_d, tmr_inc;
  logic                              rh_q, clr;
  assign edg     = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign clr     = bus.resethist & ~rh_q;
  assign tmr_inc = &tmr_q ? tmr_q : tmr_q + DLYW'(1);
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    for (int i = 0; i < NCHAN; i++) begin
      cnt_d[i] = clr ? '0 : (bus.count_enable && edg[i] && !(&cnt_q[i])) ? cnt_q[i] + CNTW'(1) : cnt_q[i];
      ovf_d[i] = !clr && (ovf_q[i] || (bus.count_enable && edg[i] && (&cnt_q[i])));
    end
  end
  // A simultaneous ch0 edge re-arms the measurement even while reporting one.
  always_comb begin
    st_d  = st_q;
    tmr_d = tmr_q;
    dly_d = dly_q;
    if (clr) begin
      st_d  = IDLE;
      tmr_d = '0;
      dly_d = '0;
    end else if (st_q == IDLE) begin
      st_d  = (edg[0] && !edg[1]) ? ARMED : IDLE;
      tmr_d = '0;
      dly_d = (edg[0] && edg[1]) ? '0 : dly_q;
    end else begin
      dly_d = edg[1] ? tmr_inc : dly_q;
      st_d  = (edg[1] && !edg[0]) ? IDLE : ARMED;
      tmr_d = edg[0] ? '0 : tmr_inc;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
      rh_q   <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= '0;
      dly_q  <= '0;
      tmr_q  <= '0;
      st_q   <= IDLE;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.trig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      rh_q   <= bus.resethist;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      dly_q  <= dly_d;
      tmr_q  <= tmr_d;
      st_q   <= st_d;
    end
  end
  assign bus.histos       = cnt_q;
  assign bus.delaycounter = dly_q;
  assign bus.overflow     = ovf_q;
endmodule

// File: tb/tb_trig_histogrammer.sv
// tb_trig_histogrammer: directed stimulus checked against a timestamp-based behavioural model
module tb_trig_histogrammer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  trig_histogrammer_if #(.NCHAN(8), .CNTW(32), .DLYW(8)) bus ();
  trig_histogrammer dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  // Model: remember raw samples, detect a rise two samples back, timestamp ch0/ch1 detections.
  logic [7:0]       hs [3];
  logic             rh_p, m_arm, pl_en = 1'b0, chk_en = 1'b0;
  logic [7:0][31:0] m_cnt;
  logic [7:0]       m_ovf, m_dly, m_e;
  logic             m_clr;
  int               cyc = 0, t0;
  assign m_e   = hs[1] & ~hs[2];
  assign m_clr = bus.resethist & ~rh_p;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) hs[i] <= '0;
      rh_p <= 1'b0; m_cnt <= '0; m_ovf <= '0; m_dly <= '0; m_arm <= 1'b0; t0 <= 0;
    end else begin
      hs[0] <= bus.trig_in; hs[1] <= hs[0]; hs[2] <= hs[1];
      rh_p <= bus.resethist;
      for (int i = 0; i < 8; i++) begin
        if (m_clr) begin
          m_cnt[i] <= '0; m_ovf[i] <= 1'b0;
        end else if (bus.count_enable && m_e[i]) begin
          if (m_cnt[i] == 32'hFFFF_FFFF) m_ovf[i] <= 1'b1;
          else m_cnt[i] <= m_cnt[i] + 32'd1;
        end
      end
      if (pl_en) m_cnt[5] <= 32'hFFFF_FFFE;
      if (m_clr) begin
        m_dly <= '0; m_arm <= 1'b0;
      end else begin
        if (m_e[1] && m_arm) m_dly <= (cyc - t0 > 255) ? 8'd255 : 8'(cyc - t0);
        else if (m_e[1] && m_e[0]) m_dly <= '0;
        if (m_e[0]) begin
          m_arm <= m_arm | ~m_e[1]; t0 <= cyc;
        end else if (m_e[1]) m_arm <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("model histos", bus.histos, m_cnt);
    chk("model overflow", 256'(bus.overflow), 256'(m_ovf));
    chk("model delay", 256'(bus.delaycounter), 256'(m_dly));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse(input int ch);
    bus.trig_in[ch] = 1'b1; tick(1);
    bus.trig_in[ch] = 1'b0; tick(2);
  endtask
  task automatic delay_run(input int gap);
    bus.trig_in[0] = 1'b1; tick(1); bus.trig_in[0] = 1'b0;
    tick(gap - 1);
    bus.trig_in[1] = 1'b1; tick(1); bus.trig_in[1] = 1'b0;
    tick(4);
  endtask

  logic [7:0][31:0] tmp;
  initial begin
    bus.trig_in = '0; bus.count_enable = 1'b1; bus.resethist = 1'b0;
    tick(2);
    chk("reset histos", bus.histos, '0);
    chk("reset delay", 256'(bus.delaycounter), 256'd0);
    chk("reset overflow", 256'(bus.overflow), 256'd0);
    reset_n = 1'b1;
    chk_en = 1'b1;
    tick(2);
    // Latency: rise sampled at posedge k appears after posedge k+2.
    bus.trig_in[3] = 1'b1; tick(1); bus.trig_in[3] = 1'b0;
    chk("lat k", 256'(bus.histos[3]), 256'd0);
    tick(1);
    chk("lat k+1", 256'(bus.histos[3]), 256'd0);
    tick(1);
    chk("lat k+2", 256'(bus.histos[3]), 256'd1);
    repeat (4) pulse(3);
    tick(3);
    chk("ch3 five", 256'(bus.histos[3]), 256'd5);
    chk("others zero", bus.histos & ~{224'd0, 32'hFFFF_FFFF} << 96, '0);
    chk("no overflow", 256'(bus.overflow), 256'd0);
    bus.count_enable = 1'b0;
    repeat (3) pulse(0);
    bus.count_enable = 1'b1;
    repeat (2) pulse(0);
    tick(3);
    chk("ch0 enable", 256'(bus.histos[0]), 256'd2);
    delay_run(17);
    chk("delay 17", 256'(bus.delaycounter), 256'd17);
    delay_run(400);
    chk("delay sat", 256'(bus.delaycounter), 256'd255);
    bus.trig_in[1:0] = 2'b11; tick(1); bus.trig_in[1:0] = 2'b00; tick(4);
    chk("delay simul", 256'(bus.delaycounter), 256'd0);
    chk_en = 1'b0; pl_en = 1'b1;
    tmp = dut.cnt_q; tmp[5] = 32'hFFFF_FFFE;
    force dut.cnt_q = tmp;
    tick(1);
    release dut.cnt_q;
    pl_en = 1'b0; chk_en = 1'b1;
    tick(1);
    repeat (3) pulse(5);
    tick(3);
    chk("ch5 sat", 256'(bus.histos[5]), 256'hFFFF_FFFF);
    chk("ch5 ovf", 256'(bus.overflow), 256'h20);
    bus.resethist = 1'b1; tick(1);
    chk("clr histos", bus.histos, '0);
    chk("clr ovf", 256'(bus.overflow), 256'd0);
    chk("clr delay", 256'(bus.delaycounter), 256'd0);
    tick(5);
    pulse(2);
    tick(40);
    chk("held no reclear", 256'(bus.histos[2]), 256'd1);
    bus.resethist = 1'b0; tick(3);
    bus.trig_in[2] = 1'b1; tick(1); bus.trig_in[2] = 1'b0; tick(1);
    bus.resethist = 1'b1; tick(1);
    chk("edge on clr dropped", 256'(bus.histos[2]), 256'd0);
    tick(3);
    bus.resethist = 1'b0;
    pulse(4); pulse(4);
    bus.trig_in[0] = 1'b1; tick(1); bus.trig_in[0] = 1'b0; tick(4);
    chk("pre-abort count", 256'(bus.histos[4]), 256'd2);
    #3 reset_n = 1'b0;
    #1;
    chk("abort histos", bus.histos, '0);
    chk("abort delay", 256'(bus.delaycounter), 256'd0);
    chk("abort ovf", 256'(bus.overflow), 256'd0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    pulse(1);
    tick(3);
    chk("ch1 alone delay", 256'(bus.delaycounter), 256'd0);
    chk("ch1 alone count", 256'(bus.histos[1]), 256'd1);
    tick(2);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
